// File: rtl/load_mshr_ctrl_pkg.sv
// rtl/load_mshr_ctrl_pkg.sv - shared types for the load miss-status controller
package load_mshr_ctrl_pkg;

  localparam int MSHR_SZ    = 4;
  localparam int MSHR_IDX_W = $clog2(MSHR_SZ);

  typedef logic [MSHR_IDX_W-1:0] MSHR_IDX;

  typedef enum logic [1:0] {
    MSHR_FREE       = 2'd0,
    MSHR_WAIT_ISSUE = 2'd1,
    MSHR_WAIT_DATA  = 2'd2
  } MSHR_STATE;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  // data[0] is the low word of the returned block
  typedef struct packed {
    logic             valid;
    MSHR_IDX          mshr_idx;
    logic [1:0][31:0] data;
  } LOAD_BUFFER_CACHE_PACKET;

  function automatic logic [28:0] block_of(input logic [31:0] addr);
    return addr[31:3];
  endfunction

endpackage

// File: rtl/psel_gen.sv
// rtl/psel_gen.sv - priority selector granting up to REQS requesters, lowest index first
module psel_gen #(
  parameter int WIDTH = 4,
  parameter int REQS  = 1
) (
  input  logic [WIDTH-1:0]      req,
  output logic [WIDTH*REQS-1:0] gnt_bus,
  output logic                  empty
);

  logic [WIDTH-1:0] taken;
  logic             found;

  always_comb begin
    taken   = '0;
    gnt_bus = '0;
    found   = 1'b0;
    for (int r = 0; r < REQS; r++) begin
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (req[i] && !taken[i] && !found) begin
          gnt_bus[r*WIDTH+i] = 1'b1;
          taken[i]           = 1'b1;
          found              = 1'b1;
        end
      end
    end
  end

  assign empty = ~|req;

endmodule

// File: rtl/load_mshr_ctrl.sv
// rtl/load_mshr_ctrl.sv - load miss allocation/merge, round-robin bus issue and tag-matched fill
module load_mshr_ctrl
  import load_mshr_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    miss_req_valid,
  input  logic [31:0]             miss_req_addr,
  output logic                    miss_ack,
  output MSHR_IDX                 miss_mshr_idx,
  output logic                    mshr_full,
  output logic                    mem_bus_req,
  input  logic                    mem_bus_gnt,
  output MEM_COMMAND              proc2mem_command,
  output logic [31:0]             proc2mem_addr,
  input  logic [3:0]              mem2proc_transaction_tag,
  input  logic [63:0]             mem2proc_data,
  input  logic [3:0]              mem2proc_data_tag,
  output LOAD_BUFFER_CACHE_PACKET load_buffer_cache_packet
);

  MSHR_STATE   state [MSHR_SZ];
  logic [28:0] blk   [MSHR_SZ];
  logic [3:0]  tag   [MSHR_SZ];
  MSHR_IDX     rr_ptr;

  logic [28:0] miss_blk;
  logic        unused_addr_bits;

  assign miss_blk         = block_of(miss_req_addr);
  assign unused_addr_bits = ^miss_req_addr[2:0];

  logic [MSHR_SZ-1:0] free_vec;
  logic [MSHR_SZ-1:0] free_gnt;
  logic               free_none;
  MSHR_IDX            alloc_idx;

  always_comb begin
    free_vec  = '0;
    alloc_idx = '0;
    for (int i = 0; i < MSHR_SZ; i++) begin
      free_vec[i] = (state[i] == MSHR_FREE);
      if (free_gnt[i]) alloc_idx = MSHR_IDX'(i);
    end
  end

  psel_gen #(
    .WIDTH (MSHR_SZ),
    .REQS  (1)
  ) u_free_sel (
    .req     (free_vec),
    .gnt_bus (free_gnt),
    .empty   (free_none)
  );

  assign mshr_full = free_none;

  logic    fill_hit;
  MSHR_IDX fill_idx;

  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = 0; i < MSHR_SZ; i++) begin
      if (!fill_hit && !reset && mem2proc_data_tag != 4'd0 &&
          state[i] == MSHR_WAIT_DATA && tag[i] == mem2proc_data_tag) begin
        fill_hit = 1'b1;
        fill_idx = MSHR_IDX'(i);
      end
    end
  end

  // Round-robin scan starting at rr_ptr; the pointer only moves on an accepted grant
  logic    issue_hit;
  MSHR_IDX issue_idx;
  MSHR_IDX rr_cand;
  logic    issue_fire;

  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    rr_cand   = '0;
    for (int k = 0; k < MSHR_SZ; k++) begin
      rr_cand = MSHR_IDX'((int'(rr_ptr) + k) % MSHR_SZ);
      if (!issue_hit && !reset && state[rr_cand] == MSHR_WAIT_ISSUE) begin
        issue_hit = 1'b1;
        issue_idx = rr_cand;
      end
    end
  end

  assign issue_fire = issue_hit && mem_bus_gnt && (mem2proc_transaction_tag != 4'd0);

  logic    merge_hit;
  MSHR_IDX merge_idx;
  logic    fill_collide;
  logic    alloc_fire;
  MSHR_IDX ack_idx;

  always_comb begin
    merge_hit    = 1'b0;
    merge_idx    = '0;
    fill_collide = fill_hit && (blk[fill_idx] == miss_blk);
    alloc_fire   = 1'b0;
    miss_ack     = 1'b0;
    ack_idx      = '0;
    for (int i = 0; i < MSHR_SZ; i++) begin
      if (!merge_hit && state[i] != MSHR_FREE && blk[i] == miss_blk &&
          !(fill_hit && fill_idx == MSHR_IDX'(i))) begin
        merge_hit = 1'b1;
        merge_idx = MSHR_IDX'(i);
      end
    end
    // A miss to the block being filled is bounced; the retry hits the cache
    if (miss_req_valid && !reset && !fill_collide) begin
      if (merge_hit) begin
        miss_ack = 1'b1;
        ack_idx  = merge_idx;
      end else if (!free_none) begin
        miss_ack   = 1'b1;
        alloc_fire = 1'b1;
        ack_idx    = alloc_idx;
      end
    end
  end

  assign miss_mshr_idx = ack_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_SZ; i++) begin
        state[i] <= MSHR_FREE;
        blk[i]   <= '0;
        tag[i]   <= '0;
      end
      rr_ptr <= '0;
    end else begin
      if (fill_hit) begin
        state[fill_idx] <= MSHR_FREE;
      end
      if (issue_fire) begin
        state[issue_idx] <= MSHR_WAIT_DATA;
        tag[issue_idx]   <= mem2proc_transaction_tag;
        rr_ptr           <= MSHR_IDX'((int'(issue_idx) + 1) % MSHR_SZ);
      end
      if (alloc_fire) begin
        state[alloc_idx] <= MSHR_WAIT_ISSUE;
        blk[alloc_idx]   <= miss_blk;
      end
    end
  end

  assign mem_bus_req      = issue_hit;
  assign proc2mem_command = issue_hit ? MEM_LOAD : MEM_NONE;
  assign proc2mem_addr    = issue_hit ? {blk[issue_idx], 3'b000} : 32'd0;

  always_comb begin
    load_buffer_cache_packet = '0;
    if (fill_hit) begin
      load_buffer_cache_packet.valid    = 1'b1;
      load_buffer_cache_packet.mshr_idx = fill_idx;
      load_buffer_cache_packet.data     = mem2proc_data;
    end
  end

endmodule

// File: tb/tb_load_mshr_ctrl.sv
// tb/tb_load_mshr_ctrl.sv - self-checking bench for load_mshr_ctrl
module tb_load_mshr_ctrl;
  import load_mshr_ctrl_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    miss_req_valid;
  logic [31:0]             miss_req_addr;
  logic                    miss_ack;
  MSHR_IDX                 miss_mshr_idx;
  logic                    mshr_full;
  logic                    mem_bus_req;
  logic                    mem_bus_gnt;
  MEM_COMMAND              proc2mem_command;
  logic [31:0]             proc2mem_addr;
  logic [3:0]              mem2proc_transaction_tag;
  logic [63:0]             mem2proc_data;
  logic [3:0]              mem2proc_data_tag;
  LOAD_BUFFER_CACHE_PACKET load_buffer_cache_packet;

  always #5 clock = ~clock;

  load_mshr_ctrl dut (
    .clock                    (clock),
    .reset                    (reset),
    .miss_req_valid           (miss_req_valid),
    .miss_req_addr            (miss_req_addr),
    .miss_ack                 (miss_ack),
    .miss_mshr_idx            (miss_mshr_idx),
    .mshr_full                (mshr_full),
    .mem_bus_req              (mem_bus_req),
    .mem_bus_gnt              (mem_bus_gnt),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .load_buffer_cache_packet (load_buffer_cache_packet)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: each slot is busy or not, and a busy slot has either been sent to memory or not
  bit          m_busy   [MSHR_SZ];
  bit          m_issued [MSHR_SZ];
  logic [28:0] m_blk    [MSHR_SZ];
  logic [3:0]  m_tag    [MSHR_SZ];
  int          m_rr;

  logic                    s_ack;
  MSHR_IDX                 s_idx;
  logic                    s_full;
  logic                    s_req;
  MEM_COMMAND              s_cmd;
  logic [31:0]             s_addr;
  LOAD_BUFFER_CACHE_PACKET s_pkt;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MSHR_SZ; i++) begin
      m_busy[i]   = 1'b0;
      m_issued[i] = 1'b0;
      m_blk[i]    = '0;
      m_tag[i]    = '0;
    end
    m_rr = 0;
  endtask

  function automatic bit tag_in_use(input logic [3:0] t);
    for (int i = 0; i < MSHR_SZ; i++)
      if (m_busy[i] && m_issued[i] && m_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] unused_tag();
    int base;
    base = $urandom_range(0, 14);
    for (int k = 0; k < 15; k++) begin
      if (!tag_in_use(4'((base + k) % 15 + 1))) return 4'((base + k) % 15 + 1);
    end
    return 4'd15;
  endfunction

  // Drive one cycle of inputs, compare against the reference, then advance the reference
  task automatic step(input logic v, input logic [31:0] a, input logic g, input logic [3:0] tt,
                      input logic [63:0] d, input logic [3:0] dt, input logic rst);
    bit          e_fill, e_iss, e_ack, e_alloc, e_full;
    int          fi, ii, ai;
    logic [28:0] mb;
    LOAD_BUFFER_CACHE_PACKET ep;
    miss_req_valid           = v;
    miss_req_addr            = a;
    mem_bus_gnt              = g;
    mem2proc_transaction_tag = tt;
    mem2proc_data            = d;
    mem2proc_data_tag        = dt;
    reset                    = rst;
    #1;
    s_ack  = miss_ack;
    s_idx  = miss_mshr_idx;
    s_full = mshr_full;
    s_req  = mem_bus_req;
    s_cmd  = proc2mem_command;
    s_addr = proc2mem_addr;
    s_pkt  = load_buffer_cache_packet;
    if (rst) begin
      check("rst_ack", s_ack, 0);
      check("rst_req", s_req, 0);
      check("rst_pkt", s_pkt, 0);
      model_clear();
    end else begin
      e_fill = 0; fi = 0;
      if (dt != 0)
        for (int i = 0; i < MSHR_SZ; i++)
          if (!e_fill && m_busy[i] && m_issued[i] && m_tag[i] == dt) begin e_fill = 1; fi = i; end
      e_iss = 0; ii = 0;
      for (int k = 0; k < MSHR_SZ; k++)
        if (!e_iss && m_busy[(m_rr + k) % MSHR_SZ] && !m_issued[(m_rr + k) % MSHR_SZ]) begin
          e_iss = 1; ii = (m_rr + k) % MSHR_SZ;
        end
      mb = a[31:3]; e_ack = 0; ai = 0; e_alloc = 0;
      if (v && !(e_fill && m_blk[fi] == mb)) begin
        for (int i = 0; i < MSHR_SZ; i++)
          if (!e_ack && m_busy[i] && m_blk[i] == mb) begin e_ack = 1; ai = i; end
        for (int i = 0; i < MSHR_SZ; i++)
          if (!e_ack && !m_busy[i]) begin e_ack = 1; ai = i; e_alloc = 1; end
      end
      e_full = 1;
      for (int i = 0; i < MSHR_SZ; i++) if (!m_busy[i]) e_full = 0;
      ep = '0;
      if (e_fill) begin ep.valid = 1'b1; ep.mshr_idx = MSHR_IDX'(fi); ep.data = d; end
      check("ack", s_ack, e_ack);
      check("idx", s_idx, e_ack ? ai : 0);
      check("full", s_full, e_full);
      check("req", s_req, e_iss);
      check("cmd", s_cmd, e_iss ? MEM_LOAD : MEM_NONE);
      check("addr", s_addr, e_iss ? {m_blk[ii], 3'b000} : 32'd0);
      check("pkt", s_pkt, ep);
      if (e_fill) m_busy[fi] = 0;
      if (e_iss && g && tt != 0) begin
        m_issued[ii] = 1; m_tag[ii] = tt; m_rr = (ii + 1) % MSHR_SZ;
      end
      if (e_alloc) begin m_busy[ai] = 1; m_issued[ai] = 0; m_blk[ai] = mb; end
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic v, input logic [31:0] a);
    step(v, a, 1'b0, 4'd0, 64'd0, 4'd0, 1'b0);
  endtask

  initial begin
    logic        v, g, rst;
    logic [31:0] a;
    logic [3:0]  tt, dt;
    int          pick, r;
    model_clear();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    idle(0, 0);
    check("reset_ack", s_ack, 0);
    check("reset_idx", s_idx, 0);
    check("reset_full", s_full, 0);
    check("reset_req", s_req, 0);
    check("reset_cmd", s_cmd, MEM_NONE);
    check("reset_addr", s_addr, 0);
    check("reset_pkt", s_pkt, 0);

    idle(1, 32'h1004);
    check("single_ack", s_ack, 1);
    check("single_idx", s_idx, 0);
    step(0, 0, 1, 4'd3, 0, 0, 0);
    check("single_req", s_req, 1);
    check("single_addr", s_addr, 32'h1000);
    idle(1, 32'h1004);
    check("merge_ack", s_ack, 1);
    check("merge_idx", s_idx, 0);
    check("merge_no_req", s_req, 0);
    step(0, 0, 0, 0, 64'hAABBCCDD_11223344, 4'd3, 0);
    check("fill_valid", s_pkt.valid, 1);
    check("fill_idx", s_pkt.mshr_idx, 0);
    check("fill_word0", s_pkt.data[0], 32'h11223344);
    check("fill_word1", s_pkt.data[1], 32'hAABBCCDD);

    idle(1, 32'h3000);
    check("realloc_idx", s_idx, 0);
    step(0, 0, 1, 4'd0, 0, 0, 0);
    check("rej_addr", s_addr, 32'h3000);
    step(0, 0, 1, 4'd5, 0, 0, 0);
    check("reissue_req", s_req, 1);
    check("reissue_addr", s_addr, 32'h3000);

    idle(1, 32'h2000);
    check("alloc1_idx", s_idx, 1);
    step(0, 0, 1, 4'd2, 0, 0, 0);
    check("issue1_addr", s_addr, 32'h2000);
    step(0, 0, 0, 0, 64'h5555_0000_5555_0000, 4'd5, 0);
    check("ooo_fill5_idx", s_pkt.mshr_idx, 0);
    step(1, 32'h2004, 0, 0, 64'h2222_0000_2222_0000, 4'd2, 0);
    check("ooo_fill2_idx", s_pkt.mshr_idx, 1);
    check("collide_ack", s_ack, 0);

    idle(1, 32'h4000);
    idle(1, 32'h5000);
    idle(1, 32'h6000);
    idle(1, 32'h7000);
    check("alloc3_idx", s_idx, 3);
    step(1, 32'h8000, 1, 4'd7, 0, 0, 0);
    check("full_ack", s_ack, 0);
    check("full_flag", s_full, 1);
    check("rr_addr", s_addr, 32'h6000);
    step(1, 32'h8000, 1, 4'd8, 0, 0, 0);
    check("rr_next_addr", s_addr, 32'h7000);
    step(0, 0, 1, 4'd9, 0, 0, 0);
    check("rr_wrap_addr", s_addr, 32'h4000);
    step(1, 32'h8000, 0, 0, 64'h7777, 4'd7, 0);
    check("fill_cycle_ack", s_ack, 0);
    check("fill_cycle_full", s_full, 1);
    check("fill_cycle_idx", s_pkt.mshr_idx, 2);
    idle(1, 32'h8000);
    check("after_fill_ack", s_ack, 1);
    check("after_fill_idx", s_idx, 2);
    check("after_fill_full", s_full, 0);

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 64'h9999, 4'd9, 0);
    check("late_tag_pkt", s_pkt.valid, 0);
    check("late_tag_full", s_full, 0);
    check("late_tag_req", s_req, 0);

    for (int n = 0; n < 2000; n++) begin
      v  = ($urandom_range(0, 99) < 60);
      a  = 32'h0001_0000 + ($urandom_range(0, 7) << 3) + $urandom_range(0, 7);
      g  = ($urandom_range(0, 99) < 50);
      tt = ($urandom_range(0, 99) < 15) ? 4'd0 : unused_tag();
      r  = $urandom_range(0, 99);
      dt = 4'd0;
      if (r < 40) begin
        pick = $urandom_range(0, MSHR_SZ - 1);
        for (int k = 0; k < MSHR_SZ; k++)
          if (dt == 0 && m_busy[(pick + k) % MSHR_SZ] && m_issued[(pick + k) % MSHR_SZ]) begin
            dt = m_tag[(pick + k) % MSHR_SZ];
            if ($urandom_range(0, 99) < 30) a = {m_blk[(pick + k) % MSHR_SZ], 3'($urandom_range(0, 7))};
          end
      end else if (r < 50) begin
        dt = unused_tag();
      end
      rst = ($urandom_range(0, 299) == 0);
      step(v, a, g, tt, {$urandom, $urandom}, dt, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
